// File: rtl/gray_counter_updown.sv
// N-bit up/down counter with registered binary and Gray views, synchronous
// load, selectable wrap/saturate at the end points, wrap pulse and terminal-count flag.
module gray_counter_updown #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT);
  localparam bit               WRAP_EN = (WRAP != 32'sd0);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d, gray_q;
  logic             wrap_q, wrap_d;

  // Next-count selection: load beats enable; end points either wrap or hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        if (bin_q != MAX_C) begin
          bin_d = bin_q + ONE_C;
        end else if (WRAP_EN) begin
          bin_d  = ZERO_C;
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q;
        end
      end else begin
        if (bin_q != ZERO_C) begin
          bin_d = bin_q - ONE_C;
        end else if (WRAP_EN) begin
          bin_d  = MAX_C;
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q;
        end
      end
    end else begin
      bin_d = bin_q;
    end
  end

  // Gray is registered from the next binary value so the output never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= INIT_C;
      gray_q <= bin2gray(INIT_C);
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= bin2gray(bin_d);
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;
  assign tc   = up ? (bin_q == MAX_C) : (bin_q == ZERO_C);

endmodule

// File: tb/tb_gray_counter_updown.sv
// Scoreboard bench: three counter configurations share one randomized stimulus
// stream; a reference model queues expectations and a negedge monitor checks them.
module tb_gray_counter_updown;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [5:0] load_val;
  logic [3:0] g0, b0, g1, b1;
  logic [5:0] g2, b2;
  logic       w0, w1, w2, t0, t1, t2;

  always #5 clk = ~clk;

  gray_counter_updown #(.WIDTH(4), .WRAP(1), .INIT(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .gray(g0), .bin(b0), .wrap(w0), .tc(t0));
  gray_counter_updown #(.WIDTH(4), .WRAP(0), .INIT(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .gray(g1), .bin(b1), .wrap(w1), .tc(t1));
  gray_counter_updown #(.WIDTH(6), .WRAP(1), .INIT(5)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .gray(g2), .bin(b2), .wrap(w2), .tc(t2));

  typedef struct {
    int b;
    int g;
    bit w;
    bit mv;
  } exp_t;

  exp_t sbq [3][$];
  int   mcnt [3];
  int   mwid [3]  = '{4, 4, 6};
  int   mwrp [3]  = '{1, 0, 1};
  int   minit [3] = '{0, 3, 5};
  int   prev_g [3];
  bit   have_prev [3] = '{1'b0, 1'b0, 1'b0};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int k, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, expv, $time);
    end
  endtask

  // Reference model: advance each configuration's count by the rules, queue the outcome.
  task automatic step(input bit r, input bit l, input bit e, input bit u, input int lv);
    int   modulus, nxt;
    bit   wr;
    exp_t x;
    rst = r; load = l; en = e; up = u; load_val = 6'(lv);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      modulus = 1 << mwid[k];
      wr = 1'b0;
      nxt = mcnt[k];
      if (r) nxt = minit[k];
      else if (l) nxt = lv % modulus;
      else if (e && u) begin
        if (mcnt[k] + 1 < modulus) nxt = mcnt[k] + 1;
        else if (mwrp[k] == 1) begin nxt = 0; wr = 1'b1; end
      end else if (e && !u) begin
        if (mcnt[k] > 0) nxt = mcnt[k] - 1;
        else if (mwrp[k] == 1) begin nxt = modulus - 1; wr = 1'b1; end
      end
      x.mv = !r && !l && e && (nxt != mcnt[k]);
      mcnt[k] = nxt;
      x.b = nxt;
      x.g = nxt ^ (nxt >> 1);
      x.w = wr;
      sbq[k].push_back(x);
    end
    #7;
  endtask

  // Monitor: pops one expectation per configuration each cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    int   ab, ag, maxv;
    bit   aw, at, etc;
    for (int k = 0; k < 3; k++) begin
      if (sbq[k].size() > 0) begin
        e = sbq[k].pop_front();
        case (k)
          0:       begin ab = int'(b0); ag = int'(g0); aw = w0; at = t0; end
          1:       begin ab = int'(b1); ag = int'(g1); aw = w1; at = t1; end
          default: begin ab = int'(b2); ag = int'(g2); aw = w2; at = t2; end
        endcase
        maxv = (1 << mwid[k]) - 1;
        etc = (up === 1'b1) ? (e.b == maxv) : (e.b == 0);
        chk("bin", k, ab, e.b);
        chk("gray", k, ag, e.g);
        chk("wrap", k, int'(aw), int'(e.w));
        chk("tc", k, int'(at), int'(etc));
        if (e.mv && have_prev[k]) chk("gray_one_bit_step", k, $countones(ag ^ prev_g[k]), 1);
        prev_g[k] = ag;
        have_prev[k] = 1'b1;
      end
    end
  end

  initial begin
    bit r, l, e, u;
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 0);
    // Up-count through a full cycle and wrap.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    // Down-count from reset.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    // Saturation region: load 14, count up past the top, then back down.
    step(1'b0, 1'b1, 1'b0, 1'b1, 14);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    // Load wins over enable, then hold.
    step(1'b0, 1'b1, 1'b1, 1'b1, 9);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Reset mid-count at 7, and reset on an edge where a wrap is due.
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 63);
    step(1'b1, 1'b0, 1'b1, 1'b1, 0);
    // A reset pulse between edges must be ignored.
    rst = 1'b1; #1; rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    // Alternating direction from zero: wraps every cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, (i % 2) == 1, 0);
    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(39) == 0);
      l = ($urandom_range(9) == 0);
      e = ($urandom_range(3) != 0);
      u = $urandom_range(1);
      step(r, l, e, u, int'($urandom_range(63)));
    end
    en = 1'b0; load = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("scoreboard_drained", k, sbq[k].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
